// File: rtl/ahb_arbiter_pkg.sv
// Shared AMBA definitions for the bridge: HTRANS encodings, arbiter states,
// the per-master control payload and small decode helpers.
package ahb_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 4;
  localparam int unsigned IDX_W       = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] ST_PARK   = 2'd0;
  localparam logic [1:0] ST_OWNED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
  } ahb_ctrl_t;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_MASTERS); i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // SEQ and BUSY mean the owner is inside a burst and must keep the bus.
  function automatic logic is_burst_cont(input logic [1:0] t);
    logic r;
    r = 1'b0;
    case (t)
      HTRANS_SEQ, HTRANS_BUSY:   r = 1'b1;
      HTRANS_IDLE, HTRANS_NONSEQ: r = 1'b0;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: starts after the last owner and wraps.
module rr_pick
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      idx = IDX_W'((int'(last) + i) % int'(NUM_MASTERS));
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB multi-master arbiter and address/write-data mux in front of one bridge
// slave port; round-robin with burst, lock and hold-limit handling.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [NUM_MASTERS-1:0]            HBUSREQ,
  input  logic [NUM_MASTERS-1:0]            HLOCK,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR_M,
  input  logic [NUM_MASTERS*2-1:0]          HTRANS_M,
  input  logic [NUM_MASTERS-1:0]            HWRITE_M,
  input  logic [NUM_MASTERS*3-1:0]          HSIZE_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic                              HREADY,
  output logic [NUM_MASTERS-1:0]            HGRANT,
  output logic [1:0]                        HMASTER,
  output logic                              HMASTLOCK,
  output logic [ADDR_WIDTH-1:0]             HADDR,
  output logic [1:0]                        HTRANS,
  output logic                              HWRITE,
  output logic [2:0]                        HSIZE,
  output logic [DATA_WIDTH-1:0]             HWDATA
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       data_owner_q;
  logic                   mastlock_q, mastlock_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  logic [ADDR_WIDTH-1:0]  addr_m  [NUM_MASTERS];
  ahb_ctrl_t              ctrl_m  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_m [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] winner_c;
  logic [IDX_W-1:0]       winner_idx_c;
  logic [HOLD_W-1:0]      beat_cnt_c;
  logic                   hold_limit_c;
  logic                   burst_cont_c;
  logic                   owner_req_c;
  logic                   owner_lock_c;
  logic                   other_req_c;
  logic                   any_req_c;
  logic                   rearb_c;
  ahb_ctrl_t              sel_ctrl_c;

  // Split the packed per-master buses into indexable arrays.
  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
    assign addr_m[m]  = HADDR_M[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign ctrl_m[m]  = {HTRANS_M[m*2 +: 2], HWRITE_M[m], HSIZE_M[m*3 +: 3]};
    assign wdata_m[m] = HWDATA_M[m*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req    (HBUSREQ),
    .last   (last_q),
    .winner (winner_c)
  );

  assign winner_idx_c = onehot_to_idx(MAX_MASTERS'(winner_c));
  assign burst_cont_c = is_burst_cont(ctrl_m[hmaster_q].htrans);
  assign owner_req_c  = HBUSREQ[hmaster_q];
  assign owner_lock_c = HLOCK[hmaster_q];
  assign other_req_c  = |(HBUSREQ & ~grant_q);
  assign any_req_c    = |HBUSREQ;

  // Beats including the one completing at this edge, saturating at MAX_HOLD.
  assign beat_cnt_c   = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
  assign hold_limit_c = (beat_cnt_c == HOLD_W'(MAX_HOLD));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_PARK;
      grant_q      <= NUM_MASTERS'(1);
      hmaster_q    <= '0;
      last_q       <= IDX_W'(NUM_MASTERS - 1);
      data_owner_q <= '0;
      mastlock_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      hmaster_q  <= hmaster_d;
      last_q     <= last_d;
      mastlock_q <= mastlock_d;
      hold_q     <= hold_d;
      if (HREADY) data_owner_q <= hmaster_q;
    end
  end

  // Next-state and arbitration decision; everything holds while HREADY=0.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hmaster_d  = hmaster_q;
    last_d     = last_q;
    mastlock_d = mastlock_q;
    hold_d     = hold_q;
    rearb_c    = 1'b0;
    if (HREADY) begin
      case (state_q)
        ST_PARK:   rearb_c = 1'b1;
        ST_OWNED:  rearb_c = (hold_limit_c && other_req_c) || !(burst_cont_c || owner_req_c);
        ST_LOCKED: rearb_c = !(owner_lock_c || burst_cont_c);
        default:   rearb_c = 1'b1;
      endcase
      if (rearb_c) begin
        if (any_req_c) begin
          grant_d    = winner_c;
          hmaster_d  = winner_idx_c;
          last_d     = winner_idx_c;
          mastlock_d = |(HLOCK & winner_c);
          state_d    = (|(HLOCK & winner_c)) ? ST_LOCKED : ST_OWNED;
        end else begin
          grant_d    = NUM_MASTERS'(1);
          hmaster_d  = '0;
          mastlock_d = 1'b0;
          state_d    = ST_PARK;
        end
      end
      if (state_q == ST_PARK || state_d == ST_PARK || hmaster_d != hmaster_q) begin
        hold_d = '0;
      end else begin
        hold_d = beat_cnt_c;
      end
    end
  end

  // Parked bus shows IDLE unless master 0 is actually requesting.
  always_comb begin
    sel_ctrl_c = ctrl_m[hmaster_q];
    if (state_q == ST_PARK && !HBUSREQ[0]) sel_ctrl_c.htrans = HTRANS_IDLE;
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;
  assign HADDR     = addr_m[hmaster_q];
  assign HTRANS    = sel_ctrl_c.htrans;
  assign HWRITE    = sel_ctrl_c.hwrite;
  assign HSIZE     = sel_ctrl_c.hsize;
  assign HWDATA    = wdata_m[data_owner_q];

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: instance a uses MAX_HOLD=16, instance b
// MAX_HOLD=4; both see the same stimulus.
module tb_ahb_arbiter;
  import ahb_arbiter_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic HCLK, HRESETn, HREADY;
  logic [NM-1:0]    HBUSREQ, HLOCK, HWRITE_M;
  logic [NM*AW-1:0] HADDR_M;
  logic [NM*2-1:0]  HTRANS_M;
  logic [NM*3-1:0]  HSIZE_M;
  logic [NM*DW-1:0] HWDATA_M;

  logic [NM-1:0] a_hgrant, b_hgrant;
  logic [1:0]    a_hmaster, b_hmaster, a_htrans, b_htrans;
  logic          a_hmastlock, b_hmastlock, a_hwrite, b_hwrite;
  logic [AW-1:0] a_haddr, b_haddr;
  logic [2:0]    a_hsize, b_hsize;
  logic [DW-1:0] a_hwdata, b_hwdata;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(16)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M),
    .HWDATA_M(HWDATA_M), .HREADY(HREADY), .HGRANT(a_hgrant), .HMASTER(a_hmaster),
    .HMASTLOCK(a_hmastlock), .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite),
    .HSIZE(a_hsize), .HWDATA(a_hwdata)
  );

  ahb_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(4)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M),
    .HWDATA_M(HWDATA_M), .HREADY(HREADY), .HGRANT(b_hgrant), .HMASTER(b_hmaster),
    .HMASTLOCK(b_hmastlock), .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite),
    .HSIZE(b_hsize), .HWDATA(b_hwdata)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] addr_of(input int m);
    return 32'hA000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] data_of(input int m);
    return 32'hD000_0000 + 32'(m);
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_trans(input int m, input logic [1:0] t);
    HTRANS_M[m*2 +: 2] = t;
  endtask

  task automatic do_reset();
    HBUSREQ  = '0;
    HLOCK    = '0;
    HTRANS_M = '0;
    HREADY   = 1'b1;
    HRESETn  = 1'b0;
    tick();
    HRESETn  = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL reset_grant got %b want 001", a_hgrant); end
    checks++; if (a_hmaster !== 2'd0) begin errors++; $display("FAIL reset_hmaster got %0d want 0", a_hmaster); end
    checks++; if (a_hmastlock !== 1'b0) begin errors++; $display("FAIL reset_mastlock got %b want 0", a_hmastlock); end
    checks++; if (a_hwdata !== data_of(0)) begin errors++; $display("FAIL reset_hwdata got %h want %h", a_hwdata, data_of(0)); end
    tick();
    HRESETn  = 1'b1;
    HBUSREQ  = 3'b000;
    HTRANS_M = 6'b101010;
    tick();
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL park_grant got %b want 001", a_hgrant); end
    checks++; if (a_hmaster !== 2'd0) begin errors++; $display("FAIL park_hmaster got %0d want 0", a_hmaster); end
    checks++; if (a_htrans !== HTRANS_IDLE) begin errors++; $display("FAIL park_htrans got %b want 00", a_htrans); end
  endtask

  task automatic test_round_robin();
    do_reset();
    HBUSREQ = 3'b001;
    tick();
    checks++; if (a_hmaster !== 2'd0) begin errors++; $display("FAIL rr_m0_hmaster got %0d want 0", a_hmaster); end
    HBUSREQ = 3'b110;
    set_trans(1, HTRANS_NONSEQ);
    set_trans(2, HTRANS_NONSEQ);
    #1;
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL rr_latency got %b want 001", a_hgrant); end
    tick();
    checks++; if (a_hgrant !== 3'b010) begin errors++; $display("FAIL rr_grant1 got %b want 010", a_hgrant); end
    checks++; if (a_hmaster !== 2'd1) begin errors++; $display("FAIL rr_hmaster1 got %0d want 1", a_hmaster); end
    checks++; if (a_haddr !== addr_of(1)) begin errors++; $display("FAIL rr_haddr1 got %h want %h", a_haddr, addr_of(1)); end
    checks++; if (a_hsize !== 3'd1) begin errors++; $display("FAIL rr_hsize1 got %0d want 1", a_hsize); end
    tick();
    checks++; if (a_hgrant !== 3'b010) begin errors++; $display("FAIL rr_keep1 got %b want 010", a_hgrant); end
    HBUSREQ = 3'b100;
    set_trans(1, HTRANS_IDLE);
    tick();
    checks++; if (a_hgrant !== 3'b100) begin errors++; $display("FAIL rr_grant2 got %b want 100", a_hgrant); end
    checks++; if (a_hmaster !== 2'd2) begin errors++; $display("FAIL rr_hmaster2 got %0d want 2", a_hmaster); end
    HBUSREQ = 3'b000;
    set_trans(2, HTRANS_IDLE);
    tick();
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL rr_repark got %b want 001", a_hgrant); end
  endtask

  task automatic test_burst_wait();
    do_reset();
    HBUSREQ = 3'b010;
    tick();
    checks++; if (a_hgrant !== 3'b010) begin errors++; $display("FAIL bw_grant got %b want 010", a_hgrant); end
    HBUSREQ = 3'b110;
    set_trans(2, HTRANS_NONSEQ);
    for (int k = 1; k <= 8; k++) begin
      set_trans(1, (k == 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
      if (k == 8) HBUSREQ = 3'b100;
      if (k == 4) begin
        HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
          tick();
          checks++; if (a_hgrant !== 3'b010 || a_hmaster !== 2'd1) begin errors++; $display("FAIL bw_stall%0d got %b/%0d want 010/1", w, a_hgrant, a_hmaster); end
        end
        HREADY = 1'b1;
      end
      tick();
      checks++; if (a_hgrant !== 3'b010) begin errors++; $display("FAIL bw_beat%0d got %b want 010", k, a_hgrant); end
    end
    set_trans(1, HTRANS_IDLE);
    tick();
    checks++; if (a_hgrant !== 3'b100) begin errors++; $display("FAIL bw_handover got %b want 100", a_hgrant); end
  endtask

  task automatic test_lock();
    do_reset();
    HBUSREQ = 3'b001;
    HLOCK   = 3'b001;
    tick();
    checks++; if (b_hmastlock !== 1'b1) begin errors++; $display("FAIL lk_mastlock got %b want 1", b_hmastlock); end
    HBUSREQ = 3'b101;
    set_trans(2, HTRANS_NONSEQ);
    for (int k = 1; k <= 8; k++) begin
      set_trans(0, (k == 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
      if (k == 8) begin
        HLOCK   = 3'b000;
        HBUSREQ = 3'b100;
      end
      tick();
      checks++; if (b_hgrant !== 3'b001 || b_hmastlock !== 1'b1) begin errors++; $display("FAIL lk_beat%0d got %b/%b want 001/1", k, b_hgrant, b_hmastlock); end
    end
    set_trans(0, HTRANS_IDLE);
    tick();
    checks++; if (b_hgrant !== 3'b100) begin errors++; $display("FAIL lk_release got %b want 100", b_hgrant); end
    checks++; if (b_hmastlock !== 1'b0) begin errors++; $display("FAIL lk_unlock got %b want 0", b_hmastlock); end
  endtask

  task automatic test_preempt();
    logic [2:0] exp_g;
    do_reset();
    HBUSREQ = 3'b010;
    tick();
    HBUSREQ = 3'b110;
    set_trans(2, HTRANS_NONSEQ);
    for (int k = 1; k <= 4; k++) begin
      set_trans(1, (k == 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
      tick();
      exp_g = (k < 4) ? 3'b010 : 3'b100;
      checks++; if (b_hgrant !== exp_g) begin errors++; $display("FAIL pe_beat%0d got %b want %b", k, b_hgrant, exp_g); end
    end
    checks++; if (b_hmaster !== 2'd2) begin errors++; $display("FAIL pe_hmaster got %0d want 2", b_hmaster); end
    checks++; if (a_hgrant !== 3'b010) begin errors++; $display("FAIL pe_nolimit got %b want 010", a_hgrant); end
  endtask

  task automatic test_handover_wdata();
    do_reset();
    HWRITE_M = 3'b111;
    HBUSREQ  = 3'b010;
    tick();
    checks++; if (a_hwdata !== data_of(0)) begin errors++; $display("FAIL wd_prev0 got %h want %h", a_hwdata, data_of(0)); end
    HBUSREQ = 3'b100;
    set_trans(1, HTRANS_NONSEQ);
    #1;
    checks++; if (a_htrans !== HTRANS_NONSEQ || a_hwrite !== 1'b1) begin errors++; $display("FAIL wd_addr_ctrl got %b/%b want 10/1", a_htrans, a_hwrite); end
    tick();
    checks++; if (a_hmaster !== 2'd2) begin errors++; $display("FAIL wd_hmaster got %0d want 2", a_hmaster); end
    checks++; if (a_hwdata !== data_of(1)) begin errors++; $display("FAIL wd_prev1 got %h want %h", a_hwdata, data_of(1)); end
    set_trans(1, HTRANS_IDLE);
    set_trans(2, HTRANS_NONSEQ);
    tick();
    checks++; if (a_hwdata !== data_of(2)) begin errors++; $display("FAIL wd_own2 got %h want %h", a_hwdata, data_of(2)); end
    HWRITE_M = 3'b000;
  endtask

  task automatic test_pulse();
    do_reset();
    HREADY  = 1'b0;
    HBUSREQ = 3'b100;
    tick();
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL pu_stall got %b want 001", a_hgrant); end
    HBUSREQ = 3'b000;
    HREADY  = 1'b1;
    tick();
    checks++; if (a_hgrant !== 3'b001 || a_hmaster !== 2'd0) begin errors++; $display("FAIL pu_ignored got %b/%0d want 001/0", a_hgrant, a_hmaster); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    HBUSREQ = 3'b010;
    tick();
    set_trans(1, HTRANS_NONSEQ);
    tick();
    set_trans(1, HTRANS_SEQ);
    tick();
    HRESETn = 1'b0;
    #2;
    checks++; if (a_hgrant !== 3'b001 || a_hmaster !== 2'd0) begin errors++; $display("FAIL rm_async got %b/%0d want 001/0", a_hgrant, a_hmaster); end
    HBUSREQ = 3'b100;
    tick();
    checks++; if (a_hgrant !== 3'b001) begin errors++; $display("FAIL rm_held got %b want 001", a_hgrant); end
    HRESETn = 1'b1;
    tick();
    checks++; if (a_hgrant !== 3'b100 || a_hmaster !== 2'd2) begin errors++; $display("FAIL rm_resume got %b/%0d want 100/2", a_hgrant, a_hmaster); end
  endtask

  initial begin
    HRESETn  = 1'b1;
    HREADY   = 1'b1;
    HBUSREQ  = '0;
    HLOCK    = '0;
    HTRANS_M = '0;
    HWRITE_M = '0;
    HSIZE_M  = {3'd2, 3'd1, 3'd0};
    for (int m = 0; m < int'(NM); m++) begin
      HADDR_M[m*AW +: AW]  = addr_of(m);
      HWDATA_M[m*DW +: DW] = data_of(m);
    end
    test_reset();
    test_round_robin();
    test_burst_wait();
    test_lock();
    test_preempt();
    test_handover_wdata();
    test_pulse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
